// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared constants and types for the rvc_asap end-of-test logic.
//   EBREAK_OPCODE      : retired-instruction encoding that halts a hart
//   D_MEM_REGION_FLOOR : default base address of the snapshot window
//   eot_status_t       : EotStatus encoding (running / ebreak / timeout)
//   eot_state_t        : end-of-test monitor states
// Also defines RVC_ASAP_DFF, the async active-low reset flop used by every
// register in this block.
`ifndef RVC_ASAP_DFF
`define RVC_ASAP_DFF(q, d, clk, rst_n, rst_val) \
  always_ff @(posedge clk or negedge rst_n) \
    if (!rst_n) q <= (rst_val); \
    else q <= (d);
`endif

package rvc_asap_pkg;

  localparam logic [31:0] EBREAK_OPCODE      = 32'h0010_0073;
  localparam logic [31:0] D_MEM_REGION_FLOOR = 32'h0001_0000;

  typedef enum logic [1:0] {
    EOT_RUNNING = 2'd0,
    EOT_EBREAK  = 2'd1,
    EOT_TIMEOUT = 2'd2
  } eot_status_t;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SNAP_REQ  = 3'd1,
    SNAP_WAIT = 3'd2,
    SNAP_OUT  = 3'd3,
    DONE      = 3'd4
  } eot_state_t;

endpackage

// File: rtl/rvc_asap_sat_cnt.sv
// rvc_asap_sat_cnt: W-bit up counter with enable that sticks at all-ones.
//   i_clk   : clock, rising edge
//   i_rst_n : async active-low reset, clears the count
//   i_en    : count this edge
//   o_cnt   : current count
`ifndef RVC_ASAP_DFF
`define RVC_ASAP_DFF(q, d, clk, rst_n, rst_val) \
  always_ff @(posedge clk or negedge rst_n) \
    if (!rst_n) q <= (rst_val); \
    else q <= (d);
`endif

module rvc_asap_sat_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = (i_en && (r_cnt != '1)) ? r_cnt + W'(1) : r_cnt;

  `RVC_ASAP_DFF(r_cnt, w_cnt_nxt, i_clk, i_rst_n, '0)

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rvc_asap_eot_monitor.sv
// rvc_asap_eot_monitor: watches per-hart retire streams for EBREAK, counts
// enabled cycles for a timeout, and on end-of-test reads SNAP_WORDS words
// from memory and streams them out as valid/ready beats.
//   Clock, RstN          : clock (rising) and async active-low reset
//   Enable               : monitoring / cycle counting active
//   InstrValid, Instr    : per-hart retire strobe and instruction
//   MemRdEn/Addr/Data    : memory read port, data one cycle after MemRdEn
//   SnapValid/Ready/Addr/Data : snapshot beat stream
//   HartHalted           : sticky per-hart EBREAK seen
//   EotStatus            : 0 running, 1 ebreak, 2 timeout
//   EotDone              : snapshot complete
//   CycleCount           : enabled cycles spent in RUN (saturating)
`ifndef RVC_ASAP_DFF
`define RVC_ASAP_DFF(q, d, clk, rst_n, rst_val) \
  always_ff @(posedge clk or negedge rst_n) \
    if (!rst_n) q <= (rst_val); \
    else q <= (d);
`endif

module rvc_asap_eot_monitor
  import rvc_asap_pkg::*;
#(
  parameter int          NUM_HARTS      = 1,
  parameter int          TIMEOUT_W      = 32,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] SNAP_BASE      = D_MEM_REGION_FLOOR,
  parameter int          SNAP_WORDS     = 16,
  parameter bit          EOT_ALL        = 1'b1
) (
  input  logic                       Clock,
  input  logic                       RstN,
  input  logic                       Enable,
  input  logic [NUM_HARTS-1:0]       InstrValid,
  input  logic [NUM_HARTS-1:0][31:0] Instr,
  output logic                       MemRdEn,
  output logic [31:0]                MemRdAddr,
  input  logic [31:0]                MemRdData,
  output logic                       SnapValid,
  input  logic                       SnapReady,
  output logic [31:0]                SnapAddr,
  output logic [31:0]                SnapData,
  output logic [NUM_HARTS-1:0]       HartHalted,
  output logic [1:0]                 EotStatus,
  output logic                       EotDone,
  output logic [TIMEOUT_W-1:0]       CycleCount
);

  localparam int                   IDX_W    = (SNAP_WORDS > 1) ? $clog2(SNAP_WORDS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(SNAP_WORDS - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  eot_state_t           r_state,     w_state_nxt;
  eot_status_t          r_status,    w_status_nxt;
  logic [IDX_W-1:0]     r_idx,       w_idx_nxt;
  logic [NUM_HARTS-1:0] r_halted,    w_halted_nxt;
  logic                 r_done,      w_done_nxt;
  logic                 r_rd_en,     w_rd_en_nxt;
  logic [31:0]          r_rd_addr,   w_rd_addr_nxt;
  logic                 r_snap_vld,  w_snap_vld_nxt;
  logic [31:0]          r_snap_addr, w_snap_addr_nxt;
  logic [31:0]          r_snap_data, w_snap_data_nxt;

  logic [NUM_HARTS-1:0] w_ebreak;
  logic [NUM_HARTS-1:0] w_halted_now;
  logic                 w_run;
  logic                 w_end;
  logic                 w_timeout;
  logic [TIMEOUT_W-1:0] w_cycles;

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++)
      w_ebreak[h] = InstrValid[h] && (Instr[h] == EBREAK_OPCODE);
  end

  // A halt retiring this cycle already counts towards the end condition.
  assign w_halted_now = r_halted | w_ebreak;
  assign w_run        = (r_state == RUN);
  assign w_end        = EOT_ALL ? (&w_halted_now) : (|w_halted_now);
  assign w_timeout    = Enable && (w_cycles == TO_LAST);

  rvc_asap_sat_cnt #(.W(TIMEOUT_W)) u_cyc_cnt (
    .i_clk   (Clock),
    .i_rst_n (RstN),
    .i_en    (w_run && Enable),
    .o_cnt   (w_cycles)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_status_nxt    = r_status;
    w_idx_nxt       = r_idx;
    w_halted_nxt    = r_halted;
    w_rd_addr_nxt   = r_rd_addr;
    w_snap_addr_nxt = r_snap_addr;
    w_snap_data_nxt = r_snap_data;
    w_rd_en_nxt     = 1'b0;
    w_snap_vld_nxt  = 1'b0;
    w_done_nxt      = 1'b0;

    case (r_state)
      RUN: begin
        w_halted_nxt = w_halted_now;
        // EBREAK wins over a timeout landing in the same cycle.
        if (w_end) begin
          w_status_nxt = EOT_EBREAK;
          w_state_nxt  = SNAP_REQ;
        end else if (w_timeout) begin
          w_status_nxt = EOT_TIMEOUT;
          w_state_nxt  = SNAP_REQ;
        end
      end
      SNAP_REQ:  w_state_nxt = SNAP_WAIT;
      SNAP_WAIT: begin
        w_snap_data_nxt = MemRdData;
        w_snap_addr_nxt = r_rd_addr;
        w_state_nxt     = SNAP_OUT;
      end
      SNAP_OUT: begin
        if (SnapReady) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = SNAP_REQ;
          end
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase

    // Outputs are registered from the next state so each one is high for
    // exactly the cycles spent in its state.
    if (w_state_nxt == SNAP_REQ) begin
      w_rd_en_nxt   = 1'b1;
      w_rd_addr_nxt = SNAP_BASE + (32'(w_idx_nxt) << 2);
    end
    w_snap_vld_nxt = (w_state_nxt == SNAP_OUT);
    w_done_nxt     = (w_state_nxt == DONE);
  end

  `RVC_ASAP_DFF(r_state,     w_state_nxt,     Clock, RstN, RUN)
  `RVC_ASAP_DFF(r_status,    w_status_nxt,    Clock, RstN, EOT_RUNNING)
  `RVC_ASAP_DFF(r_idx,       w_idx_nxt,       Clock, RstN, '0)
  `RVC_ASAP_DFF(r_halted,    w_halted_nxt,    Clock, RstN, '0)
  `RVC_ASAP_DFF(r_done,      w_done_nxt,      Clock, RstN, 1'b0)
  `RVC_ASAP_DFF(r_rd_en,     w_rd_en_nxt,     Clock, RstN, 1'b0)
  `RVC_ASAP_DFF(r_rd_addr,   w_rd_addr_nxt,   Clock, RstN, '0)
  `RVC_ASAP_DFF(r_snap_vld,  w_snap_vld_nxt,  Clock, RstN, 1'b0)
  `RVC_ASAP_DFF(r_snap_addr, w_snap_addr_nxt, Clock, RstN, '0)
  `RVC_ASAP_DFF(r_snap_data, w_snap_data_nxt, Clock, RstN, '0)

  assign MemRdEn    = r_rd_en;
  assign MemRdAddr  = r_rd_addr;
  assign SnapValid  = r_snap_vld;
  assign SnapAddr   = r_snap_addr;
  assign SnapData   = r_snap_data;
  assign HartHalted = r_halted;
  assign EotStatus  = r_status;
  assign EotDone    = r_done;
  assign CycleCount = w_cycles;

endmodule
